pulse_ack_resp: RTL
===================

// Module: pulse_ack_resp
// PURPOSE
//  Destination-end responder of the toggle-based pulse handshake. Takes a toggle
//  level already brought into this domain by the stage synchronizer, turns each
//  toggle into one queued event on a valid/ready interface, and returns an ack
//  toggle level that the source domain synchronizes back. One event per toggle;
//  bursts are counted, not lost, up to pCNT_MAX.
// PARAMETERS
//  pCNT_W      4   width of pending-event counter; pCNT_MAX = 2**pCNT_W-1
//  pACK_ON_ACC 1   1: ack toggles on consumer accept; 0: ack toggles on toggle detect
// PORTS
//  clk        in   1       single clock (destination domain)
//  rst        in   1       synchronous, active-high reset
//  req_lvl    in   1       synchronized request toggle level (already double-flopped)
//  evt_ready  in   1       consumer ready
//  clr_ovf    in   1       one-cycle pulse: clears sticky ovf
//  evt_valid  out  1       >=1 event pending
//  ack_lvl    out  1       ack toggle level, to be synchronized to source domain
//  pend_cnt   out  pCNT_W  events detected and not yet accepted
//  ovf        out  1       sticky: toggle detected while pend_cnt == pCNT_MAX
// BEHAVIOUR
//  - Reset (rst=1 at edge): evt_valid=0, ack_lvl=0, pend_cnt=0, ovf=0, armed=0,
//    prev_lvl=0. All outputs registered.
//  - Arming: first edge with rst=0 loads prev_lvl<=req_lvl, armed<=1, no event;
//    a req_lvl already high at reset release is never counted.
//  - Detect: det = armed & (req_lvl ^ prev_lvl); prev_lvl<=req_lvl every cycle.
//  - Accept: acc = evt_valid & evt_ready.
//  - Counter update per edge:
//      det & !acc : pend_cnt+1, saturating at pCNT_MAX; if saturated, ovf<=1,
//                   event dropped
//      !det & acc : pend_cnt-1
//      det & acc  : unchanged (also at pCNT_MAX, no ovf)
//  - evt_valid = (pend_cnt != 0), registered alongside pend_cnt.
//  - Latency: req_lvl changes before edge N -> evt_valid=1 after edge N (one cycle).
//  - Ack: pACK_ON_ACC=1: ack_lvl toggles on the edge where acc=1.
//         pACK_ON_ACC=0: ack_lvl toggles on the edge where det=1, including
//         dropped (ovf) events.
//    Exactly one ack toggle per event under the selected rule.
//  - ovf clears only on clr_ovf or rst. clr_ovf together with a new overflow
//    in the same cycle: set wins.
//  - evt_ready is ignored while evt_valid=0. Valid is never retracted before acc.
//  - rst mid-burst: all pending events discarded, no acks issued for them, and
//    the block re-arms. Source-side toggle state is not this block's concern.
// STRUCTURE
//  - Package pulse_sync_pkg: pCNT_W default, ACK_ON_ACCEPT/ACK_ON_DETECT constants.
//  - One sub-module, tgl_edge_det (clk, rst, lvl -> det): holds the armed flag,
//    prev_lvl and the XOR.
//  - Counter, ovf and ack logic stay in the top module. No FSM beyond armed/run.
// TESTING
//  1 Reset with req_lvl=1, release, hold 5 cycles -> evt_valid=0, pend_cnt=0,
//    ack_lvl=0.
//  2 Single toggle 0->1, evt_ready=1 -> evt_valid high exactly 1 cycle, one cycle
//    after the edge; ack_lvl 0->1 on accept edge (pACK_ON_ACC=1).
//  3 Toggle every cycle x5 with evt_ready=0 -> pend_cnt=5; then ready=1 ->
//    5 accepts, 5 ack toggles, pend_cnt=0.
//  4 pCNT_W=2, 4 toggles with ready=0 -> pend_cnt=3, ovf=1; clr_ovf -> ovf=0,
//    pend_cnt stays 3.
//  5 pend_cnt=3 with pCNT_W=2, toggle and accept in the same cycle ->
//    pend_cnt=3, ovf=0.
//  6 rst with pend_cnt=2 -> next cycle all outputs 0, no ack toggle.
//    Repeat scenario 2 with pACK_ON_ACC=0: ack toggles on the detect edge.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared constants for the toggle-based pulse handshake responder.
package pulse_sync_pkg;
  localparam int PCNT_W_DEF    = 4;
  localparam bit ACK_ON_ACCEPT = 1'b1;
  localparam bit ACK_ON_DETECT = 1'b0;
endpackage

// File: rtl/tgl_edge_det.sv
// Toggle detector: one det per change of lvl, suppressed on the first cycle after reset.
module tgl_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic det
);
  logic armed;
  logic prev_lvl;

  // The first post-reset edge only captures the level, so a level already high
  // at release never counts as a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      prev_lvl <= 1'b0;
    end else begin
      armed    <= 1'b1;
      prev_lvl <= lvl;
    end
  end

  assign det = armed & (lvl ^ prev_lvl);
endmodule

// File: rtl/pulse_ack_resp.sv
// Destination-end responder: toggles become queued valid/ready events, acks return as a toggle level.
module pulse_ack_resp
  import pulse_sync_pkg::*;
#(
  parameter int pCNT_W      = PCNT_W_DEF,
  parameter bit pACK_ON_ACC = ACK_ON_ACCEPT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_lvl,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic              ack_lvl,
  output logic [pCNT_W-1:0] pend_cnt,
  output logic              ovf
);
  localparam logic [pCNT_W-1:0] CNT_MAX = '1;

  logic              det;
  logic              acc;
  logic              sat;
  logic              drop;
  logic [pCNT_W-1:0] cnt_nxt;

  tgl_edge_det u_det (
    .clk (clk),
    .rst (rst),
    .lvl (req_lvl),
    .det (det)
  );

  assign acc  = evt_valid & evt_ready;
  assign sat  = (pend_cnt == CNT_MAX);
  assign drop = det & ~acc & sat;

  // A detect and an accept in the same cycle cancel, even when saturated.
  always_comb begin
    cnt_nxt = pend_cnt;
    case ({det, acc})
      2'b10:   if (!sat) cnt_nxt = pend_cnt + 1'b1;
      2'b01:   cnt_nxt = pend_cnt - 1'b1;
      default: cnt_nxt = pend_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt  <= '0;
      evt_valid <= 1'b0;
      ovf       <= 1'b0;
      ack_lvl   <= 1'b0;
    end else begin
      pend_cnt  <= cnt_nxt;
      evt_valid <= (cnt_nxt != '0);
      ovf       <= drop | (ovf & ~clr_ovf);
      ack_lvl   <= ack_lvl ^ (pACK_ON_ACC ? acc : det);
    end
  end
endmodule
